// File: rtl/risc_vt_mem_arb.sv
// rtl/risc_vt_mem_arb.sv - two-requester (fetch/data) arbiter onto a single-outstanding memory port
// Round-robin on ties, registered outputs, read timeout in the data-wait phase.
module risc_vt_mem_arb #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic                  i_gnt,
  output logic                  i_rvalid,
  output logic                  i_err,
  output logic [DATA_WIDTH-1:0] i_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic                  d_gnt,
  output logic                  d_done,
  output logic                  d_err,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  mem_wr,
  output logic                  mem_rd,
  input  logic                  mem_wr_en,
  input  logic                  mem_rd_en,
  input  logic                  mem_dout_rdy,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_dout,
  input  logic [DATA_WIDTH-1:0] mem_din
);

  typedef enum logic [1:0] {IDLE, CMD, WAIT} state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t                state, state_n;
  logic [7:0]            cnt, cnt_n;
  logic                  last_d, last_d_n;
  logic                  src_d, src_d_n;
  logic                  pick_d;
  logic                  mem_wr_n, mem_rd_n;
  logic [ADDR_WIDTH-1:0] mem_addr_n;
  logic [DATA_WIDTH-1:0] mem_dout_n, i_rdata_n, d_rdata_n;
  logic                  i_gnt_n, i_rvalid_n, i_err_n;
  logic                  d_gnt_n, d_done_n, d_err_n;

  // last_d set means data was granted last, so fetch wins the next tie
  assign pick_d = d_req && (!i_req || !last_d);

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    last_d_n   = last_d;
    src_d_n    = src_d;
    mem_wr_n   = mem_wr;
    mem_rd_n   = mem_rd;
    mem_addr_n = mem_addr;
    mem_dout_n = mem_dout;
    i_rdata_n  = i_rdata;
    d_rdata_n  = d_rdata;
    i_gnt_n    = 1'b0;
    i_rvalid_n = 1'b0;
    i_err_n    = 1'b0;
    d_gnt_n    = 1'b0;
    d_done_n   = 1'b0;
    d_err_n    = 1'b0;
    case (state)
      IDLE: begin
        if (i_req || d_req) begin
          src_d_n    = pick_d;
          last_d_n   = pick_d;
          mem_addr_n = pick_d ? d_addr : i_addr;
          mem_wr_n   = pick_d && d_we;
          mem_rd_n   = !(pick_d && d_we);
          if (pick_d && d_we) mem_dout_n = d_wdata;
          i_gnt_n    = !pick_d;
          d_gnt_n    = pick_d;
          state_n    = CMD;
        end
      end
      CMD: begin
        if (mem_rd && mem_rd_en) begin
          mem_rd_n = 1'b0;
          cnt_n    = 8'd0;
          state_n  = WAIT;
        end else if (mem_wr && mem_wr_en) begin
          mem_wr_n = 1'b0;
          d_done_n = 1'b1;
          state_n  = IDLE;
        end
      end
      WAIT: begin
        if (mem_dout_rdy || cnt == TO_LAST) begin
          // a timed-out read completes with zero data and an error flag
          if (src_d) begin
            d_rdata_n = mem_dout_rdy ? mem_din : '0;
            d_done_n  = 1'b1;
            d_err_n   = !mem_dout_rdy;
          end else begin
            i_rdata_n  = mem_dout_rdy ? mem_din : '0;
            i_rvalid_n = 1'b1;
            i_err_n    = !mem_dout_rdy;
          end
          state_n = IDLE;
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= 8'd0;
      last_d   <= 1'b1;
      src_d    <= 1'b0;
      mem_wr   <= 1'b0;
      mem_rd   <= 1'b0;
      mem_addr <= '0;
      mem_dout <= '0;
      i_rdata  <= '0;
      d_rdata  <= '0;
      i_gnt    <= 1'b0;
      i_rvalid <= 1'b0;
      i_err    <= 1'b0;
      d_gnt    <= 1'b0;
      d_done   <= 1'b0;
      d_err    <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      last_d   <= last_d_n;
      src_d    <= src_d_n;
      mem_wr   <= mem_wr_n;
      mem_rd   <= mem_rd_n;
      mem_addr <= mem_addr_n;
      mem_dout <= mem_dout_n;
      i_rdata  <= i_rdata_n;
      d_rdata  <= d_rdata_n;
      i_gnt    <= i_gnt_n;
      i_rvalid <= i_rvalid_n;
      i_err    <= i_err_n;
      d_gnt    <= d_gnt_n;
      d_done   <= d_done_n;
      d_err    <= d_err_n;
    end
  end

endmodule

// File: tb/tb_risc_vt_mem_arb.sv
// tb/tb_risc_vt_mem_arb.sv - self-checking bench for risc_vt_mem_arb
module tb_risc_vt_mem_arb;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [AW-1:0] i_addr = '0, d_addr = '0;
  logic [DW-1:0] d_wdata = '0, mem_din = '0;
  logic          mem_wr_en = 1'b1, mem_rd_en = 1'b1, mem_dout_rdy = 1'b1;
  logic          i_gnt, i_rvalid, i_err, d_gnt, d_done, d_err, mem_wr, mem_rd;
  logic [DW-1:0] i_rdata, d_rdata, mem_dout;
  logic [AW-1:0] mem_addr;

  risc_vt_mem_arb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_err(i_err), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_done(d_done), .d_err(d_err), .d_rdata(d_rdata),
    .mem_wr(mem_wr), .mem_rd(mem_rd), .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en),
    .mem_dout_rdy(mem_dout_rdy), .mem_addr(mem_addr), .mem_dout(mem_dout), .mem_din(mem_din)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction-level reference: one outstanding job, described by whether it is
  // still waiting for command acceptance or already waiting for read data.
  logic          m_busy = 1'b0, m_issued = 1'b0, m_src_d = 1'b0, m_last_fetch = 1'b0, m_tk = 1'b0;
  int            m_waited = 0;
  logic          e_i_gnt = 1'b0, e_i_rvalid = 1'b0, e_i_err = 1'b0;
  logic          e_d_gnt = 1'b0, e_d_done = 1'b0, e_d_err = 1'b0, e_mem_wr = 1'b0, e_mem_rd = 1'b0;
  logic [DW-1:0] e_i_rdata = '0, e_d_rdata = '0, e_mem_dout = '0;
  logic [AW-1:0] e_mem_addr = '0;

  task automatic m_finish(input logic [DW-1:0] v, input logic err);
    if (m_src_d) begin e_d_rdata = v; e_d_done = 1'b1; e_d_err = err; end
    else begin e_i_rdata = v; e_i_rvalid = 1'b1; e_i_err = err; end
    m_busy = 1'b0;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 1'b0; m_issued = 1'b0; m_src_d = 1'b0; m_last_fetch = 1'b0; m_waited = 0;
      {e_i_gnt, e_i_rvalid, e_i_err, e_d_gnt, e_d_done, e_d_err, e_mem_wr, e_mem_rd} = '0;
      e_i_rdata = '0; e_d_rdata = '0; e_mem_dout = '0; e_mem_addr = '0;
    end else begin
      {e_i_gnt, e_i_rvalid, e_i_err, e_d_gnt, e_d_done, e_d_err} = '0;
      if (!m_busy) begin
        if (i_req || d_req) begin
          m_tk = d_req && (!i_req || m_last_fetch);
          m_busy = 1'b1; m_issued = 1'b0; m_src_d = m_tk; m_last_fetch = !m_tk;
          e_mem_addr = m_tk ? d_addr : i_addr;
          if (m_tk && d_we) begin e_mem_wr = 1'b1; e_mem_dout = d_wdata; end
          else e_mem_rd = 1'b1;
          if (m_tk) e_d_gnt = 1'b1; else e_i_gnt = 1'b1;
        end
      end else if (!m_issued) begin
        if (e_mem_rd && mem_rd_en) begin e_mem_rd = 1'b0; m_issued = 1'b1; m_waited = 0; end
        else if (e_mem_wr && mem_wr_en) begin e_mem_wr = 1'b0; e_d_done = 1'b1; m_busy = 1'b0; end
      end else if (mem_dout_rdy) begin
        m_finish(mem_din, 1'b0);
      end else begin
        m_waited++;
        if (m_waited == TO) m_finish('0, 1'b1);
      end
    end
  end

  always @(posedge clk) begin
    #3;
    chk("strobes", {56'd0, i_gnt, i_rvalid, i_err, d_gnt, d_done, d_err, mem_wr, mem_rd},
        {56'd0, e_i_gnt, e_i_rvalid, e_i_err, e_d_gnt, e_d_done, e_d_err, e_mem_wr, e_mem_rd});
    chk("i_rdata", {32'd0, i_rdata}, {32'd0, e_i_rdata});
    chk("d_rdata", {32'd0, d_rdata}, {32'd0, e_d_rdata});
    if (e_mem_wr || e_mem_rd) chk("mem_addr", {32'd0, mem_addr}, {32'd0, e_mem_addr});
    if (e_mem_wr) chk("mem_dout", {32'd0, mem_dout}, {32'd0, e_mem_dout});
  end

  task automatic cyc();
    @(posedge clk);
    #4;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; i_req = 1'b0; d_req = 1'b0;
    cyc(); cyc();
    rst_n = 1'b1;
  endtask

  int gseq[$];

  initial begin
    // reset state
    cyc(); cyc();
    chk("reset_outs", {56'd0, i_gnt, i_rvalid, i_err, d_gnt, d_done, d_err, mem_wr, mem_rd}, 64'd0);
    rst_n = 1'b1;

    // single fetch read, everything ready
    mem_din = 32'h12345678; i_addr = 32'h100; i_req = 1'b1;
    cyc();
    chk("A_gnt_rd", {62'd0, i_gnt, mem_rd}, 64'd3);
    chk("A_addr", {32'd0, mem_addr}, 64'h100);
    i_req = 1'b0;
    cyc();
    chk("A_c2_rvalid", {63'd0, i_rvalid}, 64'd0);
    cyc();
    chk("A_c3_rvalid", {63'd0, i_rvalid}, 64'd1);
    chk("A_rdata", {32'd0, i_rdata}, 64'h12345678);

    // continuous contention: fetch first, then alternate
    do_reset();
    i_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
    for (int n = 0; n < 30 && gseq.size() < 4; n++) begin
      cyc();
      chk("B_both_gnt", {63'd0, i_gnt && d_gnt}, 64'd0);
      if (i_gnt) gseq.push_back(0);
      if (d_gnt) gseq.push_back(1);
    end
    chk("B_ngrants", 64'(gseq.size()), 64'd4);
    for (int n = 0; n < 4; n++)
      if (n < gseq.size()) chk("B_order", 64'(gseq[n]), 64'(n % 2));
    i_req = 1'b0; d_req = 1'b0;
    repeat (4) cyc();

    // write held through four cycles of mem_wr_en low
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'hA5A5A5A5; mem_wr_en = 1'b0;
    for (int n = 1; n <= 5; n++) begin
      cyc();
      chk("C_held", {31'd0, mem_wr, mem_addr}, {31'd0, 1'b1, 32'h40});
      chk("C_dout", {32'd0, mem_dout}, 64'hA5A5A5A5);
      if (n == 1) begin d_req = 1'b0; d_addr = 32'h77; d_wdata = 32'h0; end
      if (n == 5) mem_wr_en = 1'b1;
    end
    cyc();
    chk("C_done", {61'd0, d_done, d_err, mem_wr}, 64'b100);
    cyc();
    chk("C_done_once", {63'd0, d_done}, 64'd0);

    // data read timeout, then a normal one
    d_req = 1'b1; d_we = 1'b0; mem_dout_rdy = 1'b0; mem_din = 32'h5555AAAA;
    for (int n = 1; n <= 5; n++) begin
      cyc();
      if (n == 1) d_req = 1'b0;
      chk("D_no_done_yet", {63'd0, d_done}, 64'd0);
    end
    cyc();
    chk("D_timeout", {62'd0, d_done, d_err}, 64'd3);
    chk("D_rdata0", {32'd0, d_rdata}, 64'd0);
    d_req = 1'b1; mem_dout_rdy = 1'b1; mem_din = 32'hCAFEF00D;
    cyc(); d_req = 1'b0;
    cyc(); cyc();
    chk("D_next_ok", {62'd0, d_done, d_err}, 64'd2);
    chk("D_next_rdata", {32'd0, d_rdata}, 64'hCAFEF00D);

    // asynchronous reset during a fetch wait
    mem_dout_rdy = 1'b0; i_addr = 32'h200; i_req = 1'b1;
    cyc(); i_req = 1'b0;
    cyc();
    rst_n = 1'b0;
    #1;
    chk("E_async_strobes", {56'd0, i_gnt, i_rvalid, i_err, d_gnt, d_done, d_err, mem_wr, mem_rd}, 64'd0);
    chk("E_async_data", {i_rdata, d_rdata}, 64'd0);
    chk("E_async_addr", {32'd0, mem_addr}, 64'd0);
    cyc();
    rst_n = 1'b1; mem_dout_rdy = 1'b1;
    for (int n = 0; n < 4; n++) begin
      cyc();
      chk("E_no_rvalid", {62'd0, i_rvalid, i_err}, 64'd0);
    end

    // stray mem_dout_rdy in IDLE and CMD
    for (int n = 0; n < 3; n++) begin
      cyc();
      chk("F_idle_rdy", {62'd0, i_rvalid, d_done}, 64'd0);
    end
    mem_rd_en = 1'b0; i_req = 1'b1;
    cyc(); i_req = 1'b0;
    cyc();
    chk("F_cmd_rdy", {62'd0, mem_rd, i_rvalid}, 64'b10);
    mem_rd_en = 1'b1;
    cyc();
    chk("F_wait", {62'd0, mem_rd, i_rvalid}, 64'b00);
    cyc();
    chk("F_rvalid", {63'd0, i_rvalid}, 64'd1);

    // randomized traffic against the reference
    for (int n = 0; n < 3000; n++) begin
      cyc();
      if (!rst_n) rst_n = 1'b1;
      else if ($urandom_range(399) == 0) rst_n = 1'b0;
      if (i_req && e_i_gnt) i_req = ($urandom_range(2) == 0);
      else if (!i_req) i_req = ($urandom_range(3) == 0);
      if (d_req && e_d_gnt) begin d_req = ($urandom_range(2) == 0); d_we = $urandom_range(1); end
      else if (!d_req) begin d_req = ($urandom_range(3) == 0); d_we = $urandom_range(1); end
      i_addr = $urandom; d_addr = $urandom; d_wdata = $urandom; mem_din = $urandom;
      mem_wr_en = ($urandom_range(3) != 0);
      mem_rd_en = ($urandom_range(3) != 0);
      mem_dout_rdy = ($urandom_range(2) == 0);
    end
    cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/risc_vt_mem_arb.md
RISC_VT_MEM_ARB -- requirements
Module: risc_vt_mem_arb

Interface
REQ-001 Parameter DATA_WIDTH, default 32: data bus width.
REQ-002 Parameter ADDR_WIDTH, default 32: address bus width.
REQ-003 Parameter TIMEOUT, default 255: maximum WAIT cycles before error, range 1..255, 8-bit counter.
REQ-004 clk  in  1  single block clock, all state on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 i_req  in  1  fetch read request, held until i_gnt.
REQ-007 i_addr  in  ADDR_WIDTH  fetch address.
REQ-008 i_gnt / i_rvalid / i_err  out  1 each  fetch captured / read data valid / timeout error pulses.
REQ-009 i_rdata  out  DATA_WIDTH  fetch read data.
REQ-010 d_req, d_we  in  1 each  data request (held until d_gnt); 1 = write, 0 = read.
REQ-011 d_addr, d_wdata  in  ADDR_WIDTH, DATA_WIDTH  data address, write data.
REQ-012 d_gnt / d_done / d_err  out  1 each  data captured / transaction complete / timeout error pulses.
REQ-013 d_rdata  out  DATA_WIDTH  data read result.
REQ-014 mem_wr, mem_rd  out  1 each  memory write / read command.
REQ-015 mem_wr_en, mem_rd_en, mem_dout_rdy  in  1 each  write allowed, read allowed, read data ready.
REQ-016 mem_addr, mem_dout  out  ADDR_WIDTH, DATA_WIDTH  memory address, write data.
REQ-017 mem_din  in  DATA_WIDTH  memory read data.

Function
REQ-018 All outputs SHALL be registered; states IDLE, CMD, WAIT; one transaction outstanding.
REQ-019 IDLE: if any req, winner SHALL be chosen, addr/wdata/we/source latched, next cycle state CMD, mem_rd or mem_wr = 1 with mem_addr/mem_dout, winner gnt = 1 for exactly that cycle.
REQ-020 Arbitration: single request wins immediately; both requesting -> requester NOT granted last; last-granted pointer updates on each grant.
REQ-021 Fetch transactions SHALL always be reads; d_we selects data read/write.
REQ-022 CMD: requests ignored; command, address, data held stable until accepted (mem_rd && mem_rd_en, or mem_wr && mem_wr_en); no timeout in CMD.
REQ-023 Read accepted: next cycle mem_rd = 0, state WAIT, timeout counter = 0.
REQ-024 Write accepted: next cycle mem_wr = 0, d_done = 1 for one cycle, d_err = 0, state IDLE.
REQ-025 WAIT: mem_dout_rdy = 1 -> next cycle mem_din latched into source rdata, i_rvalid or d_done = 1 for one cycle, state IDLE.
REQ-026 WAIT without mem_dout_rdy: counter increments; on TIMEOUT-th cycle without rdy -> next cycle source rdata = 0, i_rvalid+i_err or d_done+d_err pulse one cycle, state IDLE.
REQ-027 mem_dout_rdy outside WAIT SHALL be ignored; mem_rd and mem_wr never both 1.
REQ-028 rdata outputs SHALL hold last value until next completion of same source.
REQ-029 In the completion-pulse cycle the FSM is IDLE and a pending req SHALL be arbitrated that cycle (zero-wait back-to-back); minimum read = 3 cycles req-to-rvalid, write = 2 cycles with en=1.
REQ-030 Requester changing addr/wdata after gnt SHALL not affect the current transaction.

Reset
REQ-031 rst_n = 0 SHALL immediately force state IDLE, counter 0, last-granted = data (fetch wins first tie), all outputs 0, regardless of clk.
REQ-032 Reset mid-transaction SHALL abort it with no completion, gnt or error pulse; first edge after release behaves as IDLE.

Verification
REQ-033 Fetch read, en/rdy always 1, i_addr=0x100, mem_din=0x12345678 -> mem_rd cycle 1 addr 0x100, i_gnt cycle 1, i_rvalid=1 i_rdata=0x12345678 cycle 3.
REQ-034 i_req and d_req both high continuously after reset -> grants alternate fetch, data, fetch, data; never both gnt.
REQ-035 Data write d_addr=0x40 d_wdata=0xA5A5A5A5, mem_wr_en low 4 cycles -> mem_wr/addr/data held 5 cycles, d_done 1 cycle after acceptance, d_err=0.
REQ-036 TIMEOUT=4, data read, mem_dout_rdy never -> d_done=d_err=1, d_rdata=0 on cycle after 4th WAIT cycle; next request serviced normally.
REQ-037 rst_n low during WAIT of fetch read -> outputs 0 without clk edge; later mem_dout_rdy produces no i_rvalid.
REQ-038 mem_dout_rdy pulsed in IDLE and CMD -> no rvalid/done generated.
